uart_rx_frontend: RTL and testbench

//  Oversampling UART receiver: 8N1 serial line in, parallel bytes out via valid/ready.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_frontend.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frontend.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and the
// three-sample majority vote used for bit decisions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

  localparam logic [SAMPLE_W-1:0] SAMPLE_A = SAMPLE_W'(7);
  localparam logic [SAMPLE_W-1:0] SAMPLE_B = SAMPLE_W'(8);
  localparam logic [SAMPLE_W-1:0] SAMPLE_C = SAMPLE_W'(9);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every div+1 clocks, restartable from zero via clear.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  // >= rather than == so a divider lowered mid-count still reloads instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count >= div) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

  assign tick = !clear && (count >= div);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 oversampling UART receiver: synchronizer, 16x majority sampling, start/stop
// validation and a valid/ready output holding register with overrun detection.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_rxd,
  input  logic                 io_enable,
  input  logic [DIV_WIDTH-1:0] io_baudDiv,
  output logic [DATA_BITS-1:0] io_data,
  output logic                 io_valid,
  input  logic                 io_ready,
  output logic                 io_framingError,
  output logic                 io_overrun,
  output logic                 io_busy,
  output rx_state_e            dbg_state
);

  // Handshake: io_data is held stable while io_valid is high; a byte is consumed on any
  // clock where io_valid && io_ready, after which io_valid drops unless a new byte lands.

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev;
  logic                   start_det;
  logic                   tick;
  logic [SAMPLE_W-1:0]    sample_cnt;
  logic                   samp_a;
  logic                   samp_b;
  logic                   decide;
  logic                   bit_val;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   deliver;
  logic                   frame_err;
  rx_state_e              state;
  rx_state_e              state_next;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign start_det = (state == IDLE) && io_enable && rxs_prev && !rxs;
  assign decide    = tick && (sample_cnt == SAMPLE_C);
  assign bit_val   = majority3(samp_a, samp_b, rxs);

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(start_det),
    .div  (io_baudDiv),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      rxs_prev   <= 1'b1;
      sample_cnt <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], io_rxd};
      rxs_prev <= rxs;
      if (start_det) begin
        sample_cnt <= '0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end
      if (tick && sample_cnt == SAMPLE_A) samp_a <= rxs;
      if (tick && sample_cnt == SAMPLE_B) samp_b <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    if (!io_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_det) state_next = START;
        START: if (decide) state_next = bit_val ? IDLE : DATA;
        DATA:  if (decide && bit_idx == LAST_BIT) state_next = STOP;
        STOP: begin
          if (decide) begin
            // Return to IDLE at mid-stop-bit so the next start edge is never missed.
            state_next = bit_val ? IDLE : BREAK;
            deliver    = bit_val;
            frame_err  = !bit_val;
          end
        end
        BREAK: if (rxs) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx         <= '0;
      shift           <= '0;
      io_data         <= '0;
      io_valid        <= 1'b0;
      io_framingError <= 1'b0;
      io_overrun      <= 1'b0;
    end else begin
      io_framingError <= frame_err;
      io_overrun      <= deliver && io_valid && !io_ready;
      if (state == START && decide) begin
        bit_idx <= '0;
      end
      if (state == DATA && decide) begin
        shift   <= {bit_val, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BIT_W'(1);
      end
      if (deliver && (!io_valid || io_ready)) begin
        io_data  <= shift;
        io_valid <= 1'b1;
      end else if (io_valid && io_ready) begin
        io_valid <= 1'b0;
      end
    end
  end

  assign io_busy   = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: serial frames driven bit by bit, received bytes
// checked against an expected queue, pulse counters and state checked at key points.
module tb_uart_rx_frontend;
  import uart_pkg::*;

  logic        clk;
  logic        reset;
  logic        rxd;
  logic        enable;
  logic [11:0] baud_div;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        framing_error;
  logic        overrun;
  logic        busy;
  rx_state_e   dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          fe_count = 0;
  int          ov_count = 0;
  int          bit_clks = 64;
  logic [7:0]  exp_q[$];

  uart_rx_frontend dut (
    .clk            (clk),
    .reset          (reset),
    .io_rxd         (rxd),
    .io_enable      (enable),
    .io_baudDiv     (baud_div),
    .io_data        (data),
    .io_valid       (valid),
    .io_ready       (ready),
    .io_framingError(framing_error),
    .io_overrun     (overrun),
    .io_busy        (busy),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 2 ns after the rising edge
  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(bit_clks);
    end
    rxd = stop_bit;
    clks(bit_clks);
    rxd = 1'b1;
  endtask

  // Scoreboard monitor: sampled mid-cycle, a handshake is seen exactly once
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got byte %0h expected no byte", data);
          end else begin
            check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
          end
        end
        if (framing_error) fe_count++;
        if (overrun) ov_count++;
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         n;
    reset    = 1'b1;
    rxd      = 1'b1;
    enable   = 1'b1;
    baud_div = 12'd3;
    ready    = 1'b0;
    clks(3);
    reset = 1'b0;
    clks(1);

    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_fe", {31'd0, framing_error}, 32'd0);
    check("reset_ov", {31'd0, overrun}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // 1: 0xA5, handshake 5 clocks after valid. Stop decision lands 618 clocks after the
    // start edge (2-flop sync + edge reg, then tick 9 of bit 9 at 4 clocks/tick), so valid
    // shows 44 negedges after the stop bit is driven at clock 576.
    d = 8'hA5;
    exp_q.push_back(d);
    rxd = 1'b0;
    clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(bit_clks);
    end
    rxd = 1'b1;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", n, 44);
    clks(5);
    check("t1_valid_held", {31'd0, valid}, 32'd1);
    check("t1_data_held", {24'd0, data}, 32'hA5);
    ready = 1'b1;
    clks(1);
    ready = 1'b0;
    check("t1_valid_clear", {31'd0, valid}, 32'd0);
    clks(bit_clks);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_fe_count", fe_count, 0);
    check("t1_ov_count", ov_count, 0);

    // 2: 20-clock low glitch is a false start; then enable drop aborts a frame
    ready = 1'b1;
    rxd   = 1'b0;
    clks(20);
    check("t2_state_start", 32'(dbg_state), 32'(START));
    rxd = 1'b1;
    clks(40);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_valid", {31'd0, valid}, 32'd0);
    rxd = 1'b0;
    clks(10);
    check("t2_en_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    clks(1);
    check("t2_en_abort", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    clks(4);
    enable = 1'b1;
    clks(4);
    check("t2_en_idle", 32'(dbg_state), 32'(IDLE));

    // 3: 0x00 with stop 0 and line held low 3 more bits -> framing error, BREAK
    rxd = 1'b0;
    clks(13 * bit_clks);
    check("t3_state_break", 32'(dbg_state), 32'(BREAK));
    check("t3_fe_count", fe_count, 1);
    rxd = 1'b1;
    clks(4);
    check("t3_state_idle", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("t3_rx_done", exp_q.size(), 0);

    // 4: back-to-back 0x11, 0x22 without ready -> overrun on second byte
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t4_ov_count", ov_count, 1);
    check("t4_data_kept", {24'd0, data}, 32'h11);
    check("t4_valid_held", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    clks(1);
    check("t4_valid_clear", {31'd0, valid}, 32'd0);
    check("t4_rx_done", exp_q.size(), 0);

    // 5: reset in the middle of data bit 4 of 0xFF, then 0x3C
    rxd = 1'b0;
    clks(bit_clks);
    rxd = 1'b1;
    clks(4 * bit_clks + 32);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_valid", {31'd0, valid}, 32'd0);
    clks(2 * bit_clks);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check("t5_rx_done", exp_q.size(), 0);

    // 6: div 0, 0x81 with one-clock inversion hitting sample tick 8 (offset 9 in the bit
    // once synchronizer and edge-register latency are accounted for)
    baud_div = 12'd0;
    bit_clks = 16;
    clks(4);
    d = 8'h81;
    exp_q.push_back(d);
    rxd = 1'b0;
    clks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(9);
      rxd = ~d[i];
      clks(1);
      rxd = d[i];
      clks(6);
    end
    rxd = 1'b1;
    clks(16);
    clks(20);
    check("t6_rx_done", exp_q.size(), 0);
    check("final_fe_count", fe_count, 1);
    check("final_ov_count", ov_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
